// File: rtl/seg_pkg.sv
// Shared constants for 7-segment display blocks: entry layout, blank pattern,
// hex glyph table and scan FSM state encodings.
package seg_pkg;

    localparam int DIGIT_W   = 5;
    localparam int BLANK_BIT = 4;

    localparam logic [6:0]         SEG_BLANK   = 7'b0000000;
    localparam logic [DIGIT_W-1:0] ENTRY_BLANK = 5'h10;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational decode of one digit-table entry into a segment pattern;
// the blank flag overrides the hex value.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] entry,
    output logic [6:0]         seg
);

    always_comb begin
        seg = HEX_SEG[entry[3:0]];
        if (entry[BLANK_BIT]) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered digit table,
// per-slot blanking guard and frame-aligned shadow-to-active commits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [4:0]            wr_data,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] sel,
    output logic                  frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYC);
    localparam logic [DIG_W-1:0] DIG_MAX     = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [DIG_W-1:0]   digit, digit_next;
    logic [0:0]         state, state_next;
    logic [DIGIT_W-1:0] shadow [NUM_DIGITS];
    logic [DIGIT_W-1:0] active [NUM_DIGITS];

    logic               cnt_wrap;
    logic               boundary;
    logic               copy_now;
    logic               wr_valid;
    logic [DIGIT_W-1:0] next_entry;
    logic [6:0]         dec_seg;

    always_comb begin
        cnt_wrap   = (cnt == CNT_MAX);
        boundary   = cnt_wrap && (digit == DIG_MAX);
        copy_now   = boundary && commit_pending;
        wr_valid   = wr_en && (32'(wr_addr) < NUM_DIGITS);
        cnt_next   = cnt_wrap ? '0 : cnt + CNT_W'(1);
        digit_next = digit;
        if (cnt_wrap) begin
            digit_next = (digit == DIG_MAX) ? '0 : digit + DIG_W'(1);
        end
        // Outputs are registered, so look at the entry the next cycle will show,
        // including a copy landing on this very edge.
        next_entry = copy_now ? shadow[digit_next] : active[digit_next];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BLANK: if (BLANK_CYC == 0 || cnt_next == BLANK_START) state_next = ST_DRIVE;
            default:  if (cnt_wrap && BLANK_CYC != 0) state_next = ST_BLANK;
        endcase
    end

    seg_hex_decode u_decode (
        .entry (next_entry),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            digit          <= '0;
            state          <= ST_BLANK;
            seg            <= SEG_BLANK;
            sel            <= '0;
            commit_pending <= 1'b0;
            frame_start    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= ENTRY_BLANK;
                active[i] <= ENTRY_BLANK;
            end
        end else begin
            cnt         <= cnt_next;
            digit       <= digit_next;
            state       <= state_next;
            frame_start <= boundary;
            if (state_next == ST_DRIVE) begin
                sel <= NUM_DIGITS'(1) << digit_next;
                seg <= dec_seg;
            end else begin
                sel <= '0;
                seg <= SEG_BLANK;
            end
            // Copy reads the pre-edge shadow, so a same-edge write waits for the next commit.
            if (copy_now) begin
                active <= shadow;
            end
            if (wr_valid) begin
                shadow[wr_addr[DIG_W-1:0]] <= wr_data;
            end
            commit_pending <= commit || (commit_pending && !boundary);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl: a BLANK_CYC=2 instance and a
// BLANK_CYC=0 instance share stimulus and are checked against a cycle model.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 10;
    localparam int BC = 2;
    localparam int FRAME = ND * SD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr_en, commit;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;

    logic          a_pend, a_fs, z_pend, z_fs;
    logic [6:0]    a_seg, z_seg;
    logic [ND-1:0] a_sel, z_sel;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .commit_pending(a_pend), .seg(a_seg), .sel(a_sel),
        .frame_start(a_fs)
    );

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(0)) dut_noblank (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .commit_pending(z_pend), .seg(z_seg), .sel(z_sel),
        .frame_start(z_fs)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic       pend;
        logic       fs;
        logic [6:0] zseg;
        logic [3:0] zsel;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: t counts edges since reset release; cnt = t%SD.
    int         t;
    logic [4:0] m_sh  [ND];
    logic [4:0] m_act [ND];
    logic       m_pend;

    function automatic logic [6:0] hexSeg(input logic [4:0] e);
        if (e[4]) return 7'b0000000;
        case (e[3:0])
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    task automatic cmp(input string name, input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s/%s t=%0d observed=%h expected=%h", tag, name, t, got, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp("seg",   e.tag, {1'b0, a_seg}, {1'b0, e.seg});
        cmp("sel",   e.tag, {4'b0, a_sel}, {4'b0, e.sel});
        cmp("pend",  e.tag, {7'b0, a_pend}, {7'b0, e.pend});
        cmp("fs",    e.tag, {7'b0, a_fs}, {7'b0, e.fs});
        cmp("zseg",  e.tag, {1'b0, z_seg}, {1'b0, e.zseg});
        cmp("zsel",  e.tag, {4'b0, z_sel}, {4'b0, e.zsel});
        cmp("zpend", e.tag, {7'b0, z_pend}, {7'b0, e.pend});
        cmp("zfs",   e.tag, {7'b0, z_fs}, {7'b0, e.fs});
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [2:0] a,
                                 input logic [4:0] d, input logic c, input string tag);
        exp_t e;
        logic bnd;
        int   dig;
        rst = r; wr_en = we; wr_addr = a; wr_data = d; commit = c;
        if (r) begin
            t = 0;
            m_pend = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_sh[i]  = 5'h10;
                m_act[i] = 5'h10;
            end
            e.fs = 1'b0;
        end else begin
            bnd = (t % FRAME == FRAME - 1);
            if (bnd && m_pend) begin
                for (int i = 0; i < ND; i++) m_act[i] = m_sh[i];
            end
            if (we && a < 3'(ND)) m_sh[a] = d;
            m_pend = c || (m_pend && !bnd);
            e.fs = bnd;
            t++;
        end
        dig    = (t / SD) % ND;
        e.sel  = (t % SD >= BC) ? 4'(1 << dig) : 4'b0;
        e.seg  = (e.sel != 0) ? hexSeg(m_act[dig]) : 7'b0;
        e.zsel = (t == 0) ? 4'b0 : 4'(1 << dig);
        e.zseg = (t == 0) ? 7'b0 : hexSeg(m_act[dig]);
        e.pend = m_pend;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 1'b0, "reset");
        applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 1'b0, "reset");

        // Idle scan: blank table, frame_start after edges 40 and 80.
        idle(80, "idle");

        // Load a full table mid-frame, then commit.
        applyStimulus(1'b0, 1'b1, 3'd0, 5'h01, 1'b0, "load");
        applyStimulus(1'b0, 1'b1, 3'd1, 5'h02, 1'b0, "load");
        applyStimulus(1'b0, 1'b1, 3'd2, 5'h0A, 1'b0, "load");
        applyStimulus(1'b0, 1'b1, 3'd3, 5'h05, 1'b1, "load");
        applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, "recommit");
        idle(80, "commit1");

        // Uncommitted write holds for three frames, then commit on a boundary edge.
        applyStimulus(1'b0, 1'b1, 3'd2, 5'h07, 1'b0, "nocommit");
        idle(3 * FRAME, "nocommit");
        while (t % FRAME != FRAME - 1) idle(1, "seek");
        applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, "bndcommit");
        idle(80, "bndcommit");

        // Out-of-range address is ignored.
        applyStimulus(1'b0, 1'b1, 3'd5, 5'h03, 1'b0, "oor");
        applyStimulus(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, "oor");
        idle(80, "oor");

        // Blank flag with a nonzero hex nibble, written together with commit.
        applyStimulus(1'b0, 1'b1, 3'd1, 5'h18, 1'b1, "blankbit");
        idle(80, "blankbit");

        // Reset during DRIVE with a commit pending.
        while (t % FRAME != 5) idle(1, "seek");
        applyStimulus(1'b0, 1'b1, 3'd0, 5'h03, 1'b1, "prerst");
        while (t % SD != 5) idle(1, "prerst");
        applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 1'b0, "midrst");
        idle(90, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
